// File: rtl/fetch_seq_pkg.sv
// Shared types and defaults for the fetch sequencer and its redirect holding register.
package fetch_seq_pkg;

  localparam int unsigned DEF_ADDR_W      = 16;
  localparam int unsigned DEF_RESET_DELAY = 2;
  localparam int unsigned DEF_MAX_WAIT    = 8;

  typedef enum logic [2:0] {
    RST_HOLD,
    FETCH,
    WAIT,
    ISSUE,
    HOLD,
    UPDATE
  } fetch_seq_state_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
  } redirect_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-bus signals between the sequencer (master) and the fetch stage / memory / execute side.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = fetch_seq_pkg::DEF_ADDR_W
);

  logic              imem_ready;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              enable_fetch;
  logic              enable_updatePC;
  logic              br_taken;
  logic [ADDR_W-1:0] taddr;
  logic              imem_req;
  logic              instr_valid;
  logic              timeout_err;
  logic [15:0]       fetch_count;

  modport master (
    input  imem_ready, stall, redirect_valid, redirect_addr,
    output enable_fetch, enable_updatePC, br_taken, taddr, imem_req, instr_valid,
           timeout_err, fetch_count
  );

  modport slave (
    output imem_ready, stall, redirect_valid, redirect_addr,
    input  enable_fetch, enable_updatePC, br_taken, taddr, imem_req, instr_valid,
           timeout_err, fetch_count
  );

endinterface

// File: rtl/fetch_redirect_hold.sv
// Pending branch-redirect register; a new capture always beats the clear from the update cycle.
module fetch_redirect_hold #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              capture,
  input  logic [ADDR_W-1:0] capture_addr,
  input  logic              clear,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else if (capture) begin
      valid_q <= 1'b1;
      addr_q  <= capture_addr;
    end else if (clear) begin
      valid_q <= 1'b0;
    end
  end

  assign pend_valid = valid_q;
  assign pend_addr  = addr_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Moore control FSM sequencing the fetch stage: memory handshake, downstream stall and redirects.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned RESET_DELAY = DEF_RESET_DELAY,
  parameter int unsigned MAX_WAIT    = DEF_MAX_WAIT
) (
  input logic               clock,
  input logic               reset,
  fetch_sequencer_if.master bus
);

  localparam logic [3:0] DelayInit = 4'(RESET_DELAY);
  localparam logic [7:0] WaitLast  = 8'(MAX_WAIT - 1);

  fetch_seq_state_t state_q, state_d;
  logic [3:0]       delay_q, delay_d;
  logic [7:0]       wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [15:0]      count_q, count_d;

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic              capture;

  // Redirects are only meaningful once fetching has started.
  assign capture = bus.redirect_valid && (state_q != RST_HOLD);

  fetch_redirect_hold #(
    .ADDR_W(ADDR_W)
  ) u_redirect_hold (
    .clock       (clock),
    .reset       (reset),
    .capture     (capture),
    .capture_addr(bus.redirect_addr),
    .clear       (state_q == UPDATE),
    .pend_valid  (pend_valid),
    .pend_addr   (pend_addr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= RST_HOLD;
      delay_q   <= DelayInit;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    count_d   = count_q;
    unique case (state_q)
      RST_HOLD: begin
        if (delay_q == 4'd0) state_d = FETCH;
        else                 delay_d = delay_q - 4'd1;
      end
      FETCH: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_ready) begin
          state_d = ISSUE;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q == WaitLast) begin
            timeout_d = 1'b1;
            state_d   = FETCH;
          end
        end
      end
      ISSUE: begin
        // A redirect pending on entry means this word is from the wrong path.
        if (pend_valid || !bus.stall) state_d = UPDATE;
        else                          state_d = HOLD;
      end
      HOLD: begin
        if (!bus.stall || bus.redirect_valid) state_d = UPDATE;
      end
      UPDATE: begin
        count_d = count_q + 16'd1;
        state_d = FETCH;
      end
      default: state_d = RST_HOLD;
    endcase
  end

  logic              fetch_o, upd_o, br_o, req_o, iv_o;
  logic [ADDR_W-1:0] taddr_o;

  always_comb begin
    fetch_o = 1'b0;
    upd_o   = 1'b0;
    br_o    = 1'b0;
    req_o   = 1'b0;
    iv_o    = 1'b0;
    taddr_o = '0;
    unique case (state_q)
      FETCH, WAIT: begin
        fetch_o = 1'b1;
        req_o   = 1'b1;
      end
      ISSUE:  iv_o = !pend_valid;
      HOLD:   iv_o = 1'b1;
      UPDATE: begin
        upd_o   = 1'b1;
        br_o    = pend_valid;
        taddr_o = pend_valid ? pend_addr : '0;
      end
      default: begin
      end
    endcase
  end

  assign bus.enable_fetch    = fetch_o;
  assign bus.enable_updatePC = upd_o;
  assign bus.br_taken        = br_o;
  assign bus.taddr           = taddr_o;
  assign bus.imem_req        = req_o;
  assign bus.instr_valid     = iv_o;
  assign bus.timeout_err     = timeout_q;
  assign bus.fetch_count     = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: behavioural model compared every cycle plus literal pins.
module tb_fetch_sequencer;
  import fetch_seq_pkg::*;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned RESET_DELAY = 2;
  localparam int unsigned MAX_WAIT    = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_sequencer #(
    .ADDR_W     (ADDR_W),
    .RESET_DELAY(RESET_DELAY),
    .MAX_WAIT   (MAX_WAIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch bus must show, tracked as the current activity.
  int          m_hold   = RESET_DELAY; // hold cycles left before fetching starts
  bit          m_run    = 1'b0;        // fetching has started
  bit          m_req    = 1'b0;        // memory request outstanding
  int          m_reqc   = 0;           // cycles since request launch (0 = launch cycle)
  bit          m_pres   = 1'b0;        // instruction being presented downstream
  bit          m_first  = 1'b0;        // first presentation cycle
  bit          m_upd    = 1'b0;        // PC update cycle
  bit          m_tmo    = 1'b0;
  logic [15:0] m_cnt    = '0;
  redirect_t   m_pend   = '0;

  task automatic model_init();
    m_hold  = RESET_DELAY;
    m_run   = 1'b0;
    m_req   = 1'b0;
    m_reqc  = 0;
    m_pres  = 1'b0;
    m_first = 1'b0;
    m_upd   = 1'b0;
    m_tmo   = 1'b0;
    m_cnt   = '0;
    m_pend  = '0;
  endtask

  task automatic model_step();
    redirect_t nxt;
    nxt = m_pend;
    if (bus.redirect_valid && m_run) begin
      nxt.valid = 1'b1;
      nxt.addr  = bus.redirect_addr;
    end else if (m_upd) begin
      nxt.valid = 1'b0;
    end
    if (!m_run) begin
      if (m_hold == 0) begin
        m_run  = 1'b1;
        m_req  = 1'b1;
        m_reqc = 0;
      end else begin
        m_hold--;
      end
    end else if (m_req) begin
      if (m_reqc > 0 && bus.imem_ready) begin
        m_req   = 1'b0;
        m_pres  = 1'b1;
        m_first = 1'b1;
      end else if (m_reqc == int'(MAX_WAIT)) begin
        m_tmo  = 1'b1;
        m_reqc = 0;
      end else begin
        m_reqc++;
      end
    end else if (m_pres) begin
      if (m_first ? (m_pend.valid || !bus.stall) : (!bus.stall || bus.redirect_valid)) begin
        m_pres = 1'b0;
        m_upd  = 1'b1;
      end else begin
        m_first = 1'b0;
      end
    end else if (m_upd) begin
      m_upd  = 1'b0;
      m_cnt  = m_cnt + 16'd1;
      m_req  = 1'b1;
      m_reqc = 0;
    end
    m_pend = nxt;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) model_init();
    else       model_step();
  end

  always @(negedge clock) begin
    logic        exp_br;
    logic [15:0] exp_ta;
    exp_br = m_upd && m_pend.valid;
    exp_ta = exp_br ? m_pend.addr : 16'h0;
    check("enable_fetch", 32'(bus.enable_fetch), 32'(m_req));
    check("imem_req", 32'(bus.imem_req), 32'(m_req));
    check("instr_valid", 32'(bus.instr_valid), 32'(m_pres && !(m_first && m_pend.valid)));
    check("enable_updatePC", 32'(bus.enable_updatePC), 32'(m_upd));
    check("br_taken", 32'(bus.br_taken), 32'(exp_br));
    check("taddr", 32'(bus.taddr), 32'(exp_ta));
    check("timeout_err", 32'(bus.timeout_err), 32'(m_tmo));
    check("fetch_count", 32'(bus.fetch_count), 32'(m_cnt));
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic pulse_redirect(input logic [15:0] addr);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = addr;
  endtask

  task automatic wait_upd(input int budget, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!bus.enable_updatePC && cyc < budget);
    if (!bus.enable_updatePC) begin
      n_cmp++;
      n_err++;
      $display("FAIL upd_wait: no PC update within %0d cycles", budget);
    end
  endtask

  task automatic wait_iv(input int budget);
    int n;
    n = 0;
    while (!bus.instr_valid && n < budget) begin
      tick();
      n++;
    end
    if (!bus.instr_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL iv_wait: no instr_valid within %0d cycles", budget);
    end
  endtask

  initial begin
    #100000;
    $display("watchdog expired at %0t", $time);
    $fatal(1, "bench watchdog");
  end

  initial begin
    int n;
    int cyc;
    bus.imem_ready     = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    repeat (2) tick();
    check("rst_enable_fetch", 32'(bus.enable_fetch), 32'd0);
    check("rst_fetch_count", 32'(bus.fetch_count), 32'd0);
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);

    // Reset release and steady-state cadence.
    reset = 1'b0;
    n = 0;
    while (!bus.enable_fetch && n < 20) begin
      tick();
      n++;
    end
    check("first_fetch_edge", 32'(n), 32'd3);
    wait_upd(10, cyc);
    check("first_upd_latency", 32'(cyc), 32'd3);
    check("first_upd_br", 32'(bus.br_taken), 32'd0);
    check("first_upd_taddr", 32'(bus.taddr), 32'd0);
    wait_upd(10, cyc);
    check("upd_period_2", 32'(cyc), 32'd4);
    wait_upd(10, cyc);
    check("upd_period_3", 32'(cyc), 32'd4);
    tick();
    check("count_after_3", 32'(bus.fetch_count), 32'd3);

    // Memory timeout and retry.
    bus.imem_ready = 1'b0;
    n = 0;
    while (!bus.timeout_err && n < 30) begin
      tick();
      n++;
    end
    check("timeout_latency", 32'(n), 32'd9);
    check("retry_fetch", 32'(bus.imem_req), 32'd1);
    bus.imem_ready = 1'b1;
    tick();
    tick();
    check("post_retry_issue", 32'(bus.instr_valid), 32'd1);
    wait_upd(5, cyc);
    check("timeout_sticky", 32'(bus.timeout_err), 32'd1);

    // Downstream stall for five cycles.
    bus.stall = 1'b1;
    wait_iv(10);
    n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.instr_valid) n++;
    end
    bus.stall = 1'b0;
    check("stall_iv_cycles", 32'(n), 32'd6);
    tick();
    check("stall_release_upd", 32'(bus.enable_updatePC), 32'd1);

    // Redirect during WAIT squashes the fetched word.
    tick();
    tick();
    pulse_redirect(16'h3000);
    tick();
    bus.redirect_valid = 1'b0;
    check("squash_iv", 32'(bus.instr_valid), 32'd0);
    tick();
    check("redir_upd", 32'(bus.enable_updatePC), 32'd1);
    check("redir_br", 32'(bus.br_taken), 32'd1);
    check("redir_taddr", 32'(bus.taddr), 32'h3000);
    wait_upd(10, cyc);
    check("after_redir_br", 32'(bus.br_taken), 32'd0);

    // Latest of two redirects wins.
    tick();
    pulse_redirect(16'h1111);
    tick();
    pulse_redirect(16'h2222);
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check("latest_br", 32'(bus.br_taken), 32'd1);
    check("latest_taddr", 32'(bus.taddr), 32'h2222);

    // Redirect in the UPDATE cycle applies at the following update.
    wait_upd(10, cyc);
    check("upd_cycle_br_now", 32'(bus.br_taken), 32'd0);
    pulse_redirect(16'h4567);
    tick();
    bus.redirect_valid = 1'b0;
    wait_upd(10, cyc);
    check("upd_cycle_br_next", 32'(bus.br_taken), 32'd1);
    check("upd_cycle_taddr_next", 32'(bus.taddr), 32'h4567);

    // Reset while holding with a redirect pending.
    bus.stall = 1'b1;
    wait_iv(10);
    pulse_redirect(16'h5555);
    tick();
    bus.redirect_valid = 1'b0;
    check("hold_iv", 32'(bus.instr_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_iv", 32'(bus.instr_valid), 32'd0);
    check("async_rst_timeout", 32'(bus.timeout_err), 32'd0);
    check("async_rst_count", 32'(bus.fetch_count), 32'd0);
    check("async_rst_fetch", 32'(bus.enable_fetch), 32'd0);
    tick();
    tick();
    reset     = 1'b0;
    bus.stall = 1'b0;
    wait_upd(20, cyc);
    check("post_rst_br", 32'(bus.br_taken), 32'd0);
    check("post_rst_taddr", 32'(bus.taddr), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
